// File: rtl/signal_control_pkg.sv
// Shared definitions for the signal conditioner: edge-select encodings and
// the edge qualification rule used by every channel.
package signal_control_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // True when an edge of the given direction should produce a pulse.
    function automatic logic edge_hit(input logic [1:0] mode, input logic rising);
        edge_hit = (mode == EDGE_BOTH) ||
                   ( rising && (mode == EDGE_RISE)) ||
                   (!rising && (mode == EDGE_FALL));
    endfunction

endpackage

// File: rtl/signal_conditioner_ch.sv
// One conditioner channel: synchroniser chain, persistence filter,
// qualified edge pulse and sticky flag.
module signal_conditioner_ch
    import signal_control_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal,
    input  logic [1:0] edge_mode,
    input  logic       clear,
    output logic       level,
    output logic       control,
    output logic       flag,
    output logic       flag_nxt
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   accept;
    logic                   control_nxt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], signal};
    end

    // A new level is accepted on the FILTER_CYCLES-th consecutive cycle it differs;
    // any return to the current level restarts the count.
    always_comb begin
        accept      = 1'b0;
        cnt_nxt     = '0;
        if (s != level) begin
            if (cnt == CNT_LAST) accept  = 1'b1;
            else                 cnt_nxt = cnt + CNT_W'(1);
        end
        control_nxt = accept && edge_hit(edge_mode, s);
        flag_nxt    = control_nxt | (flag & ~clear);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            level   <= 1'b0;
            control <= 1'b0;
            flag    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            level   <= accept ? s : level;
            control <= control_nxt;
            flag    <= flag_nxt;
        end
    end

endmodule

// File: rtl/signal_conditioner.sv
// Multi-channel input conditioner: independent per-channel conditioning
// plus a registered summary of all sticky flags.
module signal_conditioner
    import signal_control_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal,
    input  logic [1:0]          edge_mode,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] control,
    output logic [CHANNELS-1:0] flag,
    output logic                any_flag
);

    if (CHANNELS < 1) begin : g_chk_channels
        $error("signal_conditioner: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("signal_conditioner: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_chk_filter
        $error("signal_conditioner: FILTER_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] flag_nxt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        signal_conditioner_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .signal    (signal[i]),
            .edge_mode (edge_mode),
            .clear     (clear[i]),
            .level     (level[i]),
            .control   (control[i]),
            .flag      (flag[i]),
            .flag_nxt  (flag_nxt[i])
        );
    end

    // Built from next-state flags so any_flag lines up with flag.
    always_ff @(posedge clk) begin
        if (!rst_n) any_flag <= 1'b0;
        else        any_flag <= |flag_nxt;
    end

endmodule

// File: tb/tb_signal_conditioner.sv
// Randomised plus directed bench for signal_conditioner with a cycle-level
// reference model feeding a scoreboard queue.
module tb_signal_conditioner;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int F  = 4;

    typedef struct packed {
        logic [CH-1:0] level;
        logic [CH-1:0] control;
        logic [CH-1:0] flag;
        logic          any_flag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] signal;
    logic [1:0]    edge_mode;
    logic [CH-1:0] clear;
    logic [CH-1:0] level, control, flag;
    logic          any_flag;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   done   = 1'b0;

    signal_conditioner #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal    (signal),
        .edge_mode (edge_mode),
        .clear     (clear),
        .level     (level),
        .control   (control),
        .flag      (flag),
        .any_flag  (any_flag)
    );

    always #5 clk = ~clk;

    // Reference: the input is seen S edges late; level flips once the last F
    // seen values all disagree with it; pulses follow the edge_mode rule.
    bit raw [CH][S];
    bit win [CH][F];
    bit m_level [CH];
    bit m_flag  [CH];

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            cyc++;
            e = '0;
            for (int c = 0; c < CH; c++) begin
                if (!rst_n) begin
                    for (int i = 0; i < S; i++) raw[c][i] = 1'b0;
                    for (int i = 0; i < F; i++) win[c][i] = 1'b0;
                    m_level[c] = 1'b0;
                    m_flag[c]  = 1'b0;
                end else begin
                    bit seen, all_diff, pulse, rising;
                    seen = raw[c][S-1];
                    for (int i = S-1; i > 0; i--) raw[c][i] = raw[c][i-1];
                    raw[c][0] = signal[c];
                    for (int i = F-1; i > 0; i--) win[c][i] = win[c][i-1];
                    win[c][0] = seen;
                    all_diff = 1'b1;
                    for (int i = 0; i < F; i++)
                        if (win[c][i] == m_level[c]) all_diff = 1'b0;
                    pulse = 1'b0;
                    if (all_diff) begin
                        rising     = !m_level[c];
                        m_level[c] = !m_level[c];
                        case (edge_mode)
                            2'b01:   pulse = rising;
                            2'b10:   pulse = !rising;
                            2'b11:   pulse = 1'b1;
                            default: pulse = 1'b0;
                        endcase
                    end
                    m_flag[c]    = pulse | (m_flag[c] & !clear[c]);
                    e.control[c] = pulse;
                end
                e.level[c] = m_level[c];
                e.flag[c]  = m_flag[c];
            end
            e.any_flag = |e.flag;
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so every cycle presents a response.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level",    level,   e.level);
                chk("control",  control, e.control);
                chk("flag",     flag,    e.flag);
                chk("any_flag", {{(CH-1){1'b0}}, any_flag}, {{(CH-1){1'b0}}, e.any_flag});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold [CH];

    initial begin
        rst_n     = 1'b0;
        signal    = '0;
        clear     = '0;
        edge_mode = 2'b01;
        step(3);
        rst_n = 1'b1;

        // Rising edge on ch0 with mode 01 and a long hold.
        step(10);
        signal[0] = 1'b1;
        step(12);

        // ch1: 3-cycle glitch rejected, 4-cycle pulse accepted both ways.
        edge_mode = 2'b11;
        signal[1] = 1'b1; step(3); signal[1] = 1'b0; step(10);
        signal[1] = 1'b1; step(4); signal[1] = 1'b0; step(12);

        // ch2: falling-only mode, then no-pulse mode.
        edge_mode = 2'b10;
        signal[2] = 1'b1; step(10); signal[2] = 1'b0; step(10);
        edge_mode = 2'b00;
        signal[2] = 1'b1; step(10); signal[2] = 1'b0; step(10);

        // Clear racing a set on ch0, then a later clear.
        clear = '1; step(1); clear = '0;
        edge_mode = 2'b01;
        signal[0] = 1'b0; step(10);
        signal[0] = 1'b1; step(5);
        clear[0] = 1'b1; step(2);
        clear[0] = 1'b0; step(4);

        // Reset during ch3 filtering; input stays high across release.
        signal[3] = 1'b1; step(4);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; step(10);

        // All channels rise together with both-edge mode.
        clear = '1; signal = '0; step(12);
        clear = '0; edge_mode = 2'b11;
        signal = '1; step(10);

        // Random phase: hold lengths straddle the filter length.
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    signal[c] = ~signal[c];
                    hold[c]   = $urandom_range(1, 2*F);
                end
                hold[c]--;
                clear[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0) edge_mode = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 399) != 0);
            step(1);
        end
        rst_n = 1'b1;
        clear = '0;
        step(3);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
